// File: rtl/decog_seq.sv
// Instruction decoder with an NREGS-entry register bank, ZNC flags, a branch pulse
// and a req/ack store port; one instruction per valid/ready handshake.
module decog_seq #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 2,
   localparam int RSEL_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [DATA_W-1:0] opcode,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              br_cond,
   output logic              br_out,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [RSEL_W-1:0] rd_sel,
   output logic [DATA_W-1:0] rd_data,
   output logic [2:0]        znc
);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam logic [3:0] OPC_LD  = 4'b0000;
   localparam logic [3:0] OPC_ST  = 4'b0001;
   localparam logic [3:0] OPC_INC = 4'b0010;
   localparam logic [3:0] OPC_BR  = 4'b0011;
   localparam logic [3:0] OPC_DEC = 4'b0100;
   localparam logic [3:0] OPC_CLR = 4'b0101;

   state_t            state_r, state_nxt_s;
   logic [DATA_W-1:0] regs_r     [NREGS];
   logic [DATA_W-1:0] regs_nxt_s [NREGS];
   logic [2:0]        znc_r, znc_nxt_s;
   logic              br_r, br_nxt_s;
   logic              mem_we_r, mem_we_nxt_s;
   logic [DATA_W-1:0] mem_wdata_r, mem_wdata_nxt_s;

   logic [3:0]        opc_s;
   logic [RSEL_W-1:0] rs_s;
   logic [DATA_W-1:0] cur_s, inc_s, dec_s;
   logic              inc_c_s;

   // Z, N and C from an arithmetic result and its carry/borrow
   function automatic logic [2:0] flags_of(input logic [DATA_W-1:0] res, input logic c);
      return {(res == {DATA_W{1'b0}}), res[DATA_W-1], c};
   endfunction

   assign opc_s = opcode[DATA_W-1 -: 4];
   assign rs_s  = opcode[DATA_W-5 -: RSEL_W];
   assign cur_s = regs_r[rs_s];
   assign {inc_c_s, inc_s} = {1'b0, cur_s} + {{DATA_W{1'b0}}, 1'b1};
   assign dec_s = cur_s - {{(DATA_W-1){1'b0}}, 1'b1};

   assign instr_ready = (state_r == IDLE);
   assign br_out      = br_r;
   assign mem_we      = mem_we_r;
   assign mem_wdata   = mem_wdata_r;
   assign znc         = znc_r;
   assign rd_data     = regs_r[rd_sel];

   // Next-state decode: instructions are only taken in IDLE, the store waits for ack
   always_comb begin
      state_nxt_s     = state_r;
      regs_nxt_s      = regs_r;
      znc_nxt_s       = znc_r;
      br_nxt_s        = 1'b0;
      mem_we_nxt_s    = mem_we_r;
      mem_wdata_nxt_s = mem_wdata_r;
      case (state_r)
         IDLE: begin
            if (instr_valid) begin
               case (opc_s)
                  OPC_LD: begin
                     regs_nxt_s[rs_s] = ld_data;
                  end
                  OPC_ST: begin
                     mem_wdata_nxt_s = cur_s;
                     mem_we_nxt_s    = 1'b1;
                     state_nxt_s     = ST_WAIT;
                  end
                  OPC_INC: begin
                     regs_nxt_s[rs_s] = inc_s;
                     znc_nxt_s        = flags_of(inc_s, inc_c_s);
                  end
                  OPC_BR: begin
                     br_nxt_s = br_cond;
                  end
                  OPC_DEC: begin
                     regs_nxt_s[rs_s] = dec_s;
                     znc_nxt_s        = flags_of(dec_s, (cur_s == {DATA_W{1'b0}}));
                  end
                  OPC_CLR: begin
                     regs_nxt_s[rs_s] = {DATA_W{1'b0}};
                     znc_nxt_s        = 3'b100;
                  end
                  default: begin
                     state_nxt_s = IDLE;
                  end
               endcase
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ST_WAIT: begin
            if (mem_ack) begin
               mem_we_nxt_s = 1'b0;
               state_nxt_s  = IDLE;
            end else begin
               mem_we_nxt_s = 1'b1;
            end
         end
         default: begin
            mem_we_nxt_s = 1'b0;
            state_nxt_s  = IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any pending store immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         znc_r       <= 3'b000;
         br_r        <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_wdata_r <= {DATA_W{1'b0}};
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
      end else begin
         state_r     <= state_nxt_s;
         znc_r       <= znc_nxt_s;
         br_r        <= br_nxt_s;
         mem_we_r    <= mem_we_nxt_s;
         mem_wdata_r <= mem_wdata_nxt_s;
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= regs_nxt_s[i];
         end
      end
   end

endmodule

// File: tb/tb_decog_seq.sv
// Scoreboard bench for decog_seq: randomized instruction stream against an arithmetic
// reference model, plus directed reset, store and wide (NREGS=4, DATA_W=24) checks.
module tb_decog_seq;

   logic        clk = 1'b0;
   logic        rst_n, instr_valid, br_cond, mem_ack, rd_sel;
   logic [15:0] opcode, ld_data;
   wire         instr_ready, br_out, mem_we;
   wire  [15:0] mem_wdata, rd_data;
   wire  [2:0]  znc;

   logic        v4, brc4, ack4;
   logic [23:0] op4, ld4;
   logic [1:0]  rd4;
   wire         rdy4, br4, we4;
   wire  [23:0] wd4, rdd4;
   wire  [2:0]  znc4;

   always #5 clk = ~clk;

   decog_seq #(.DATA_W(16), .NREGS(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .opcode(opcode), .ld_data(ld_data), .br_cond(br_cond), .br_out(br_out),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .rd_sel(rd_sel), .rd_data(rd_data), .znc(znc));

   decog_seq #(.DATA_W(24), .NREGS(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .instr_valid(v4), .instr_ready(rdy4),
      .opcode(op4), .ld_data(ld4), .br_cond(brc4), .br_out(br4),
      .mem_we(we4), .mem_wdata(wd4), .mem_ack(ack4),
      .rd_sel(rd4), .rd_data(rdd4), .znc(znc4));

   typedef struct packed {
      logic [2:0]  znc;
      logic        br;
      logic        rdy;
      logic [15:0] r1;
      logic [15:0] r0;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] st_q[$];
   logic [15:0] m_regs [2];
   logic [2:0]  m_znc;
   int          checks = 0;
   int          failures = 0;
   bit          done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: applies one accepted instruction and queues the expected view
   task automatic model_apply(input logic [3:0] opc, input logic r, input logic [15:0] ld,
                              input logic brc);
      int unsigned v;
      int unsigned res;
      exp_t e;
      logic b;
      b = 1'b0;
      v = m_regs[r];
      case (opc)
         4'd0: m_regs[r] = ld;
         4'd1: st_q.push_back(m_regs[r]);
         4'd2: begin
            res = (v + 1) % 65536;
            m_znc = {res == 0, res >= 32768, (v + 1) > 65535};
            m_regs[r] = 16'(res);
         end
         4'd3: b = brc;
         4'd4: begin
            res = (v + 65535) % 65536;
            m_znc = {res == 0, res >= 32768, v == 0};
            m_regs[r] = 16'(res);
         end
         4'd5: begin
            m_regs[r] = 16'h0000;
            m_znc = 3'b100;
         end
         default: b = 1'b0;
      endcase
      e.znc = m_znc;
      e.br  = b;
      e.rdy = (opc != 4'd1);
      e.r1  = m_regs[1];
      e.r0  = m_regs[0];
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic [3:0] opc, input logic r, input logic [15:0] ld,
                        input logic brc);
      int cnt;
      @(negedge clk);
      instr_valid = 1'b1;
      opcode      = {opc, r, 11'($urandom)};
      ld_data     = ld;
      br_cond     = brc;
      cnt = 0;
      while (!instr_ready && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      if (!instr_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout ready=%b expected=1 @%0t", instr_ready, $time);
         instr_valid = 1'b0;
      end else begin
         @(posedge clk);
         model_apply(opc, r, ld, brc);
      end
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge clk);
         instr_valid = 1'b0;
         opcode      = 16'($urandom);
         br_cond     = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic issue4(input logic [3:0] opc, input logic [1:0] r, input logic [23:0] ld);
      @(negedge clk);
      v4  = 1'b1;
      op4 = {opc, r, 18'($urandom)};
      ld4 = ld;
      @(negedge clk);
      v4  = 1'b0;
   endtask

   initial begin
      logic [23:0] vals4 [4];
      rst_n = 1'b0; instr_valid = 1'b0; br_cond = 1'b0; mem_ack = 1'b0; rd_sel = 1'b0;
      opcode = 16'h0000; ld_data = 16'h0000;
      v4 = 1'b0; brc4 = 1'b0; ack4 = 1'b0; op4 = 24'h0; ld4 = 24'h0; rd4 = 2'd0;
      m_regs[0] = 16'h0000; m_regs[1] = 16'h0000; m_znc = 3'b000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset arriving in the middle of a store
      @(negedge clk);
      instr_valid = 1'b1; opcode = 16'h0800; ld_data = 16'hBEEF;
      @(negedge clk);
      opcode = 16'h1800;
      @(negedge clk);
      instr_valid = 1'b0;
      chk("pre_rst_we", mem_we, 1);
      chk("pre_rst_wdata", mem_wdata, 16'hBEEF);
      chk("pre_rst_ready", instr_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_we_async", mem_we, 0);
      chk("rst_wdata", mem_wdata, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         rd_sel = 1'(i);
         #1 chk("rst_reg", rd_data, 0);
      end
      chk("rst_znc", znc, 0);
      chk("rst_ready", instr_ready, 1);
      chk("rst_br", br_out, 0);

      // Wide instance: four registers of 24 bits
      vals4[0] = 24'h111111; vals4[1] = 24'h2ABCDE; vals4[2] = 24'h800000; vals4[3] = 24'hFFFFFF;
      for (int i = 0; i < 4; i++) issue4(4'd0, 2'(i), vals4[i]);
      for (int i = 0; i < 4; i++) begin
         rd4 = 2'(i);
         #1 chk("w_ld", rdd4, vals4[i]);
      end
      issue4(4'd2, 2'd3, 24'h0);
      chk("w_inc_znc", znc4, 3'b101);
      for (int i = 0; i < 3; i++) begin
         rd4 = 2'(i);
         #1 chk("w_untouched", rdd4, vals4[i]);
      end
      rd4 = 2'd3;
      #1 chk("w_inc_wrap", rdd4, 24'h000000);
      issue4(4'd4, 2'd2, 24'h0);
      rd4 = 2'd2;
      #1 chk("w_dec", rdd4, 24'h7FFFFF);
      chk("w_dec_znc", znc4, 3'b000);

      fork
         begin : driver
            issue(4'd0, 1'b1, 16'h00FE, 1'b0);
            issue(4'd2, 1'b1, 16'h0000, 1'b0);
            issue(4'd2, 1'b1, 16'h0000, 1'b0);
            issue(4'd0, 1'b0, 16'hFFFF, 1'b0);
            issue(4'd2, 1'b0, 16'h0000, 1'b0);
            issue(4'd4, 1'b0, 16'h0000, 1'b0);
            issue(4'd5, 1'b0, 16'h0000, 1'b0);
            issue(4'd0, 1'b1, 16'h1234, 1'b0);
            issue(4'd1, 1'b1, 16'h0000, 1'b0);
            issue(4'd3, 1'b0, 16'h0000, 1'b1);
            issue(4'd3, 1'b1, 16'h0000, 1'b0);
            issue(4'd3, 1'b0, 16'h0000, 1'b1);
            for (int i = 0; i < 300; i++) begin
               logic [3:0]  opc;
               logic [15:0] ld;
               int          k;
               k   = $urandom_range(0, 9);
               opc = (k < 8) ? 4'(k) : 4'($urandom_range(6, 15));
               ld  = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
               issue(opc, 1'($urandom_range(0, 1)), ld, 1'($urandom_range(0, 1)));
               if ($urandom_range(0, 4) == 0) gap($urandom_range(1, 2));
            end
            gap(1);
            for (int i = 0; i < 20 && mem_we; i++) @(negedge clk);
            repeat (3) @(negedge clk);
            done = 1'b1;
         end
         begin : monitor
            logic a_prev;
            exp_t e;
            a_prev = 1'b0;
            while (!done) begin
               @(negedge clk);
               if (a_prev) begin
                  if (exp_q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL exp_q_underflow size=0 expected>0 @%0t", $time);
                  end else begin
                     e = exp_q.pop_front();
                     chk("znc", znc, e.znc);
                     chk("br_out", br_out, e.br);
                     chk("ready_after", instr_ready, e.rdy);
                     rd_sel = 1'b0;
                     #1 chk("reg0", rd_data, e.r0);
                     rd_sel = 1'b1;
                     #1 chk("reg1", rd_data, e.r1);
                  end
               end else begin
                  chk("br_idle", br_out, 0);
               end
               #2 a_prev = instr_valid && instr_ready;
            end
         end
         begin : acker
            bit          in_st;
            bit          sent;
            int          d;
            int          cnt;
            int          nst;
            logic [15:0] wd;
            in_st = 1'b0; sent = 1'b0; d = 0; cnt = 0; nst = 0; wd = 16'h0;
            while (!done) begin
               @(negedge clk);
               if (!in_st) begin
                  if (mem_we) begin
                     in_st = 1'b1;
                     cnt   = 1;
                     d     = (nst == 0) ? 3 : $urandom_range(1, 4);
                     nst++;
                     if (st_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL st_unexpected mem_we=1 expected=0 @%0t", $time);
                     end else begin
                        wd = st_q.pop_front();
                        chk("st_wdata", mem_wdata, wd);
                     end
                     chk("st_ready_low", instr_ready, 0);
                     sent    = (d == 1);
                     mem_ack = sent;
                  end else begin
                     mem_ack = 1'($urandom_range(0, 1));
                  end
               end else if (sent) begin
                  chk("st_we_drop", mem_we, 0);
                  chk("st_ready_back", instr_ready, 1);
                  in_st   = 1'b0;
                  sent    = 1'b0;
                  mem_ack = 1'($urandom_range(0, 1));
               end else begin
                  cnt++;
                  chk("st_we_held", mem_we, 1);
                  chk("st_wdata_held", mem_wdata, wd);
                  chk("st_ready_held", instr_ready, 0);
                  sent    = (cnt == d);
                  mem_ack = sent;
               end
            end
            mem_ack = 1'b0;
         end
      join

      chk("exp_q_drained", exp_q.size(), 0);
      chk("st_q_drained", st_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
